// File: rtl/pipe_stage_elastic.sv
// Elastic inter-stage pipeline register with valid/ready handshake, hold/flush and perf counters.
// Build option: define PIPE_SKID_EN for a 2-entry (main + skid) stage with registered in_ready.
module pipe_stage_elastic #(
   parameter int unsigned DATA_W                   = 32,
   parameter int unsigned CTRL_W                   = 24,
   parameter int unsigned PC_W                     = 32,
   parameter logic [PC_W-1:0]   PC_RST             = PC_W'(32'hBFC00000),
   parameter logic [CTRL_W-1:0] CTRL_BUBBLE        = '0,
   parameter int unsigned CNT_W                    = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              hold,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PC_W-1:0]   in_pc,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PC_W-1:0]   out_pc,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  bubble_cnt
);

   typedef struct packed {
      logic [PC_W-1:0]   pc;
      logic [CTRL_W-1:0] ctrl;
      logic [DATA_W-1:0] data;
   } entry_t;

   localparam entry_t BUBBLE = {PC_RST, CTRL_BUBBLE, DATA_W'(0)};

   entry_t             main_q, main_d;
   logic               main_vld_q, main_vld_d;
   logic [CNT_W-1:0]   stall_q, stall_d;
   logic [CNT_W-1:0]   bubble_q, bubble_d;
   entry_t             in_entry;
   logic               accept, deliver;

   assign in_entry = {in_pc, in_ctrl, in_data};

`ifdef PIPE_SKID_EN
   entry_t skid_q, skid_d;
   logic   skid_vld_q, skid_vld_d;

   // Ready comes only from storage state and hold; no path from out_ready.
   assign in_ready = !skid_vld_q && !hold;
`else
   assign in_ready = !hold && (!main_vld_q || out_ready);
`endif

   // Hold hides the entry without touching storage.
   assign out_valid = main_vld_q && !hold;
   assign accept    = in_valid && in_ready;
   assign deliver   = out_valid && out_ready;

   assign out_pc     = main_q.pc;
   assign out_ctrl   = main_q.ctrl;
   assign out_data   = main_q.data;
   assign stall_cnt  = stall_q;
   assign bubble_cnt = bubble_q;

   // Next-state for storage; flush empties everything and wins over any accept.
   always_comb begin
      main_d     = main_q;
      main_vld_d = main_vld_q;
`ifdef PIPE_SKID_EN
      skid_d     = skid_q;
      skid_vld_d = skid_vld_q;
`endif
      if (flush) begin
         main_d     = BUBBLE;
         main_vld_d = 1'b0;
`ifdef PIPE_SKID_EN
         skid_d     = BUBBLE;
         skid_vld_d = 1'b0;
`endif
      end else begin
`ifdef PIPE_SKID_EN
         if (deliver) begin
            if (skid_vld_q) begin
               main_d     = skid_q;
               skid_d     = BUBBLE;
               skid_vld_d = 1'b0;
            end else if (accept) begin
               main_d     = in_entry;
            end else begin
               main_d     = BUBBLE;
               main_vld_d = 1'b0;
            end
         end else if (accept) begin
            if (main_vld_q) begin
               skid_d     = in_entry;
               skid_vld_d = 1'b1;
            end else begin
               main_d     = in_entry;
               main_vld_d = 1'b1;
            end
         end
`else
         if (accept) begin
            main_d     = in_entry;
            main_vld_d = 1'b1;
         end else if (deliver) begin
            main_d     = BUBBLE;
            main_vld_d = 1'b0;
         end
`endif
      end
   end

   // Saturating perf counters.
   always_comb begin
      stall_d  = stall_q;
      bubble_d = bubble_q;
      if ((hold || (main_vld_q && !out_ready)) && (stall_q != '1))
         stall_d = stall_q + CNT_W'(1);
      if ((!main_vld_q || flush) && (bubble_q != '1))
         bubble_d = bubble_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         main_q     <= BUBBLE;
         main_vld_q <= 1'b0;
         stall_q    <= '0;
         bubble_q   <= '0;
      end else begin
         main_q     <= main_d;
         main_vld_q <= main_vld_d;
         stall_q    <= stall_d;
         bubble_q   <= bubble_d;
      end
   end

`ifdef PIPE_SKID_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         skid_q     <= BUBBLE;
         skid_vld_q <= 1'b0;
      end else begin
         skid_q     <= skid_d;
         skid_vld_q <= skid_vld_d;
      end
   end
`endif

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Randomized + directed bench for pipe_stage_elastic against a queue-based reference model.
// A second instance with CNT_W=4 shares all inputs to exercise counter saturation.
module tb_pipe_stage_elastic;

   localparam logic [31:0] PC_RST = 32'hBFC00000;
`ifdef PIPE_SKID_EN
   localparam int CAP = 2;
`else
   localparam int CAP = 1;
`endif

   logic        clk = 1'b0;
   logic        rst, flush, hold, in_valid, out_ready;
   logic [31:0] in_pc, in_data;
   logic [23:0] in_ctrl;

   logic        in_ready, out_valid;
   logic [31:0] out_pc, out_data;
   logic [23:0] out_ctrl;
   logic [15:0] stall_cnt, bubble_cnt;

   logic        in_ready4, out_valid4;
   logic [31:0] out_pc4, out_data4;
   logic [23:0] out_ctrl4;
   logic [3:0]  stall_cnt4, bubble_cnt4;

   always #5 clk = ~clk;

   pipe_stage_elastic dut (
      .clk(clk), .rst(rst), .flush(flush), .hold(hold),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_pc(in_pc), .in_ctrl(in_ctrl), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .out_ctrl(out_ctrl), .out_data(out_data),
      .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
   );

   pipe_stage_elastic #(.CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .flush(flush), .hold(hold),
      .in_valid(in_valid), .in_ready(in_ready4),
      .in_pc(in_pc), .in_ctrl(in_ctrl), .in_data(in_data),
      .out_valid(out_valid4), .out_ready(out_ready),
      .out_pc(out_pc4), .out_ctrl(out_ctrl4), .out_data(out_data4),
      .stall_cnt(stall_cnt4), .bubble_cnt(bubble_cnt4)
   );

   typedef struct {
      logic [31:0] pc;
      logic [23:0] ctrl;
      logic [31:0] data;
   } ent_t;

   ent_t        q[$];
   int unsigned m_stall, m_bubble, m_stall4, m_bubble4;
   bit          model_live = 1'b0;
   int          n_checks = 0;
   int          n_fail = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit m_in_ready();
      if (hold) return 1'b0;
      if (CAP == 2) return q.size() < 2;
      return (q.size() == 0) || out_ready;
   endfunction

   // Compare every DUT output against the model's view of the stage.
   task automatic compare_all();
      logic [31:0] e_pc, e_data;
      logic [23:0] e_ctrl;
      bit          e_valid;
      e_valid = (q.size() > 0) && !hold;
      e_pc    = (q.size() > 0) ? q[0].pc   : PC_RST;
      e_ctrl  = (q.size() > 0) ? q[0].ctrl : 24'h0;
      e_data  = (q.size() > 0) ? q[0].data : 32'h0;
      check("out_valid",  64'(out_valid),  64'(e_valid));
      check("in_ready",   64'(in_ready),   64'(m_in_ready()));
      check("out_pc",     64'(out_pc),     64'(e_pc));
      check("out_ctrl",   64'(out_ctrl),   64'(e_ctrl));
      check("out_data",   64'(out_data),   64'(e_data));
      check("stall_cnt",  64'(stall_cnt),  64'(m_stall));
      check("bubble_cnt", 64'(bubble_cnt), 64'(m_bubble));
      check("out_pc4",    64'(out_pc4),    64'(e_pc));
      check("out_valid4", 64'(out_valid4), 64'(e_valid));
      check("in_ready4",  64'(in_ready4),  64'(m_in_ready()));
      check("out_data4",  64'(out_data4),  64'(e_data));
      check("out_ctrl4",  64'(out_ctrl4),  64'(e_ctrl));
      check("stall_cnt4", 64'(stall_cnt4), 64'(m_stall4));
      check("bubble_cnt4",64'(bubble_cnt4),64'(m_bubble4));
   endtask

   task automatic model_step();
      bit acc, del, st, bb;
      ent_t e;
      if (rst) begin
         q.delete();
         m_stall = 0; m_bubble = 0; m_stall4 = 0; m_bubble4 = 0;
         model_live = 1'b1;
         return;
      end
      st  = hold || ((q.size() > 0) && !out_ready);
      bb  = (q.size() == 0) || flush;
      acc = in_valid && m_in_ready();
      del = (q.size() > 0) && !hold && out_ready;
      if (st) begin
         if (m_stall  < 65535) m_stall++;
         if (m_stall4 < 15)    m_stall4++;
      end
      if (bb) begin
         if (m_bubble  < 65535) m_bubble++;
         if (m_bubble4 < 15)    m_bubble4++;
      end
      if (flush) q.delete();
      else begin
         if (del) void'(q.pop_front());
         if (acc) begin
            e.pc = in_pc; e.ctrl = in_ctrl; e.data = in_data;
            q.push_back(e);
         end
      end
   endtask

   task automatic cycle(input bit r, input bit f, input bit h, input bit iv,
                        input logic [31:0] pc, input bit ordy);
      @(negedge clk);
      rst = r; flush = f; hold = h; in_valid = iv; out_ready = ordy;
      in_pc = pc; in_ctrl = 24'($urandom); in_data = $urandom;
      #1;
      if (model_live) compare_all();
      @(posedge clk);
      model_step();
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; hold = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_pc = '0; in_ctrl = '0; in_data = '0;

      // Reset
      cycle(1, 0, 0, 0, 32'h0, 0);
      cycle(1, 0, 0, 0, 32'h0, 0);
      #1;
      check("rst_out_valid",  64'(out_valid),  64'(0));
      check("rst_out_pc",     64'(out_pc),     64'(32'hBFC00000));
      check("rst_out_ctrl",   64'(out_ctrl),   64'(0));
      check("rst_stall_cnt",  64'(stall_cnt),  64'(0));
      check("rst_bubble_cnt", 64'(bubble_cnt), 64'(0));

      // Stream
      cycle(0, 0, 0, 1, 32'h100, 1);
      cycle(0, 0, 0, 1, 32'h104, 1);
      cycle(0, 0, 0, 1, 32'h108, 1);
      #1 check("stream_pc", 64'(out_pc), 64'(32'h108));
      cycle(0, 0, 0, 0, 32'h0, 1);
      cycle(0, 0, 0, 0, 32'h0, 1);

      // Backpressure
      cycle(0, 0, 0, 1, 32'h200, 1);
      for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 32'h204 + 32'(4*i), 0);
      #1 check("bp_pc_stable", 64'(out_pc), 64'(32'h200));
      for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 32'h0, 1);

      // Hold while full
      cycle(0, 0, 0, 1, 32'h300, 0);
      for (int i = 0; i < 3; i++) cycle(0, 0, 1, 1, 32'h304, 1);
      cycle(0, 0, 0, 0, 32'h0, 0);
      #1 check("hold_reappear", 64'(out_pc), 64'(32'h300));
      cycle(0, 0, 0, 0, 32'h0, 1);
      cycle(0, 0, 0, 0, 32'h0, 1);

      // Flush beats hold and accept
      cycle(0, 0, 0, 1, 32'h400, 0);
      cycle(0, 1, 1, 1, 32'h404, 0);
      #1 check("flush_ctrl", 64'(out_ctrl), 64'(0));
      cycle(0, 0, 0, 0, 32'h0, 1);

      // Random traffic
      for (int i = 0; i < 400; i++)
         cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 19) == 0),
               ($urandom_range(0, 9) == 0), $urandom_range(0, 1) == 1,
               $urandom, $urandom_range(0, 3) != 0);

      // Counter saturation on the CNT_W=4 instance
      cycle(1, 0, 0, 0, 32'h0, 0);
      cycle(0, 0, 0, 1, 32'h500, 0);
      for (int i = 0; i < 20; i++) cycle(0, 0, 0, 0, 32'h0, 0);
      #1;
      check("sat_stall4",  64'(stall_cnt4), 64'(4'hF));
      check("sat_pc_held", 64'(out_pc4),    64'(32'h500));
      cycle(0, 0, 0, 0, 32'h0, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
